// File: rtl/ws2811_rx_decoder_pkg.sv
// Shared WS2811 timing: bit period, 0/1 high times, decision threshold, latch length.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package ws2811_rx_decoder_pkg;

  // Reference operating point shared by transmitter and receiver
  localparam int unsigned DEF_CLK_HZ   = 50_000_000;
  localparam int unsigned DEF_BIT_HZ   = 800_000;
  localparam int unsigned DEF_LATCH_US = 50;

  // Clocks per bit period
  function automatic int unsigned cycle_count(input int unsigned clk_hz, input int unsigned bit_hz);
    return clk_hz / bit_hz;
  endfunction

  // Nominal high time of a 0 bit (0.32 of the period)
  function automatic int unsigned h0_count(input int unsigned cyc);
    return (cyc * 32) / 100;
  endfunction

  // Nominal high time of a 1 bit (0.64 of the period)
  function automatic int unsigned h1_count(input int unsigned cyc);
    return (cyc * 64) / 100;
  endfunction

  // Clocks of continuous low that make a latch; split to avoid 32-bit overflow
  function automatic int unsigned latch_count(input int unsigned clk_hz, input int unsigned us);
    return us * (clk_hz / 1_000_000);
  endfunction

  localparam int unsigned CYCLE_COUNT = cycle_count(DEF_CLK_HZ, DEF_BIT_HZ);  // 62
  localparam int unsigned H0          = h0_count(CYCLE_COUNT);                // 19
  localparam int unsigned H1          = h1_count(CYCLE_COUNT);                // 39
  localparam int unsigned THRESH      = (H0 + H1) / 2;                        // 29
  localparam int unsigned LATCH_COUNT = latch_count(DEF_CLK_HZ, DEF_LATCH_US); // 2500
  localparam int unsigned MIN_HIGH    = 4;

  // GRB byte order on the wire: first byte is green, occupying the top of the word
  localparam int unsigned G_LSB = 16;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ws2811_pulse_meter.sv
// Synchronizes di, detects edges and measures high/low run lengths into strobes.
// Latency: 3 clk from di to any strobe (2-flop sync + registered strobe).
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
module ws2811_pulse_meter
  import ws2811_rx_decoder_pkg::*;
#(
  parameter int unsigned CYC_CLKS    = CYCLE_COUNT,
  parameter int unsigned THRESH_CLKS = THRESH,
  parameter int unsigned MIN_CLKS    = MIN_HIGH,
  parameter int unsigned LATCH_CLKS  = LATCH_COUNT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic di,
  output logic rise_strobe,
  output logic bit_strobe,
  output logic bit_val,
  output logic latch_strobe,
  output logic short_err,
  output logic long_err
);

  // high_cnt must hold CYC_CLKS+1 (saturation value marking an over-long pulse)
  localparam int HW = $clog2(CYC_CLKS + 2);
  localparam int LW = $clog2(LATCH_CLKS + 1);

  localparam logic [HW-1:0] HI_MAX = HW'(CYC_CLKS);
  localparam logic [HW-1:0] HI_SAT = HW'(CYC_CLKS + 1);
  localparam logic [HW-1:0] HI_THR = HW'(THRESH_CLKS);
  localparam logic [HW-1:0] HI_MIN = HW'(MIN_CLKS);
  localparam logic [LW-1:0] LO_LST = LW'(LATCH_CLKS - 1);
  localparam logic [LW-1:0] LO_MAX = LW'(LATCH_CLKS);

  logic          sync_q1, sync_q2, prev_q;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic          rise, fall;

  assign rise = sync_q2 & ~prev_q;
  assign fall = ~sync_q2 & prev_q;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= di;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  // Run-length counters; both saturate so long runs never wrap into false events
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (rise) begin
        high_cnt <= HW'(1);
      end else if (sync_q2 && high_cnt != HI_SAT) begin
        high_cnt <= high_cnt + 1'b1;
      end
      if (sync_q2) begin
        low_cnt <= '0;
      end else if (low_cnt != LO_MAX) begin
        low_cnt <= low_cnt + 1'b1;
      end
    end
  end

  // Classify each event; an over-long pulse reports only long_err, never a bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_strobe  <= 1'b0;
      bit_strobe   <= 1'b0;
      bit_val      <= 1'b0;
      latch_strobe <= 1'b0;
      short_err    <= 1'b0;
      long_err     <= 1'b0;
    end else begin
      rise_strobe  <= rise;
      bit_strobe   <= fall && (high_cnt >= HI_MIN) && (high_cnt <= HI_MAX);
      bit_val      <= (high_cnt >= HI_THR);
      short_err    <= fall && (high_cnt < HI_MIN);
      long_err     <= sync_q2 && !rise && (high_cnt == HI_MAX);
      latch_strobe <= !sync_q2 && (low_cnt == LO_LST);
    end
  end

endmodule

// File: rtl/ws2811_rx_decoder.sv
// WS2811 receiver: decodes GRB pixels with frame index, latch detection and sticky errors.
// Latency: pixel strobe 1 clk after the 24th bit strobe (about 4 clk after its falling edge).
// Backpressure: none; pix_* and frame_* are strobes the consumer must take when valid.
module ws2811_rx_decoder
  import ws2811_rx_decoder_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned BIT_HZ   = DEF_BIT_HZ,
  parameter int unsigned LATCH_US = DEF_LATCH_US,
  parameter int unsigned NUM_LEDS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       di,
  input  logic       err_clear,
  output logic       pix_valid,
  output logic [7:0] pix_green,
  output logic [7:0] pix_red,
  output logic [7:0] pix_blue,
  output logic [6:0] pix_index,
  output logic       frame_done,
  output logic [6:0] frame_pixels,
  output logic       err_short,
  output logic       err_long,
  output logic       err_partial,
  output logic       err_overflow
);

  localparam int unsigned CYC   = cycle_count(CLK_HZ, BIT_HZ);
  localparam int unsigned THR   = (h0_count(CYC) + h1_count(CYC)) / 2;
  localparam int unsigned LATCH = latch_count(CLK_HZ, LATCH_US);
  localparam logic [6:0]  PIX_MAX = 7'(NUM_LEDS);

  logic rise_strobe, bit_strobe, bit_val, latch_strobe, short_err, long_err;

  ws2811_pulse_meter #(
    .CYC_CLKS   (CYC),
    .THRESH_CLKS(THR),
    .MIN_CLKS   (MIN_HIGH),
    .LATCH_CLKS (LATCH)
  ) u_meter (
    .clk         (clk),
    .reset_n     (reset_n),
    .di          (di),
    .rise_strobe (rise_strobe),
    .bit_strobe  (bit_strobe),
    .bit_val     (bit_val),
    .latch_strobe(latch_strobe),
    .short_err   (short_err),
    .long_err    (long_err)
  );

  rx_state_t   state;
  logic [22:0] shift_q;   // the 24th bit is taken live from bit_val
  logic [4:0]  bit_cnt;
  logic [6:0]  pixel_cnt;
  logic [23:0] word;

  logic set_short, set_long, set_partial, set_overflow;

  assign word         = {shift_q, bit_val};
  assign set_short    = (state == S_HIGH) && short_err;
  assign set_long     = (state == S_HIGH) && long_err;
  assign set_partial  = (state == S_IDLE) && latch_strobe && (bit_cnt != 5'd0);
  assign set_overflow = (state == S_HIGH) && !long_err && !short_err && bit_strobe &&
                        (bit_cnt == 5'd23) && (pixel_cnt == PIX_MAX);

  // Frame FSM: bit assembly, pixel emission and latch handling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_SYNC;
      shift_q      <= '0;
      bit_cnt      <= '0;
      pixel_cnt    <= '0;
      pix_valid    <= 1'b0;
      pix_green    <= '0;
      pix_red      <= '0;
      pix_blue     <= '0;
      pix_index    <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_SYNC: begin
          // Start clean once the line has been quiet for a full latch time
          if (latch_strobe) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            pixel_cnt <= '0;
          end
        end
        S_IDLE: begin
          if (rise_strobe) begin
            state <= S_HIGH;
          end else if (latch_strobe) begin
            // Frames that produced no pixel stay silent
            if (pixel_cnt != 7'd0) begin
              frame_done   <= 1'b1;
              frame_pixels <= pixel_cnt;
            end
            pixel_cnt <= '0;
            bit_cnt   <= '0;
          end
        end
        S_HIGH: begin
          if (long_err) begin
            state   <= S_SYNC;
            bit_cnt <= '0;
          end else if (short_err) begin
            state <= S_IDLE;
          end else if (bit_strobe) begin
            state   <= S_IDLE;
            shift_q <= word[22:0];
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pixel_cnt != PIX_MAX) begin
                pix_valid <= 1'b1;
                pix_green <= word[G_LSB +: 8];
                pix_red   <= word[R_LSB +: 8];
                pix_blue  <= word[B_LSB +: 8];
                pix_index <= pixel_cnt;
                pixel_cnt <= pixel_cnt + 7'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

  // Sticky error flags; a new event in the same clock as err_clear keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_short    <= set_short    | (err_short    & ~err_clear);
      err_long     <= set_long     | (err_long     & ~err_clear);
      err_partial  <= set_partial  | (err_partial  & ~err_clear);
      err_overflow <= set_overflow | (err_overflow & ~err_clear);
    end
  end

endmodule

// File: tb/tb_ws2811_rx_decoder.sv
// Directed bench for ws2811_rx_decoder: table-driven pixel and threshold vectors plus error sequences.
module tb_ws2811_rx_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       di = 1'b0;
  logic       err_clear = 1'b0;
  logic       pix_valid;
  logic [7:0] pix_green, pix_red, pix_blue;
  logic [6:0] pix_index;
  logic       frame_done;
  logic [6:0] frame_pixels;
  logic       err_short, err_long, err_partial, err_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [7:0] g; logic [7:0] r; logic [7:0] b; logic [6:0] idx; } pix_t;
  pix_t       pq[$];
  logic [6:0] fq[$];

  ws2811_rx_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .di          (di),
    .err_clear   (err_clear),
    .pix_valid   (pix_valid),
    .pix_green   (pix_green),
    .pix_red     (pix_red),
    .pix_blue    (pix_blue),
    .pix_index   (pix_index),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_partial (err_partial),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Capture strobed outputs away from the active edge
  always @(negedge clk) begin
    if (pix_valid === 1'b1) pq.push_back('{pix_green, pix_red, pix_blue, pix_index});
    if (frame_done === 1'b1) fq.push_back(frame_pixels);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    di = 1'b1;
    tick(hi);
    di = 1'b0;
    tick(lo);
  endtask

  // Send the top nbits of w, MSB first, at nominal 62-clk bit timing
  task automatic send_bits(input logic [23:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (w[23 - i]) pulse(39, 23);
      else           pulse(19, 43);
    end
  endtask

  task automatic latch();
    tick(2520);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(2);
  endtask

  task automatic chk_pix(input string nm, input int k, input logic [7:0] g, input logic [7:0] r,
                         input logic [7:0] b, input logic [6:0] idx);
    pix_t p;
    logic present;
    present = (k < pq.size());
    p = '{8'h0, 8'h0, 8'h0, 7'h0};
    if (present) p = pq[k];
    check(nm, {present, p.idx, p.g, p.r, p.b}, {1'b1, idx, g, r, b});
  endtask

  task automatic chk_frame(input string nm, input int n, input logic [6:0] px);
    logic [6:0] fp;
    check({nm, " frame count"}, 32'(fq.size()), 32'(n));
    fp = (fq.size() > 0) ? fq[0] : 7'h7f;
    check({nm, " frame pixels"}, 32'(fp), 32'(px));
  endtask

  task automatic flush();
    pq.delete();
    fq.delete();
  endtask

  initial begin
    pix_t ptab[5];
    int   twid[6];
    logic tbit[6];
    ptab[0] = '{8'h01, 8'h02, 8'h03, 7'd0};
    ptab[1] = '{8'h80, 8'h00, 8'hFF, 7'd1};
    ptab[2] = '{8'hFF, 8'hFF, 8'hFF, 7'd2};
    ptab[3] = '{8'h00, 8'h00, 8'h00, 7'd3};
    ptab[4] = '{8'h5A, 8'hA5, 8'h69, 7'd4};
    twid[0] = 4;  tbit[0] = 1'b0;
    twid[1] = 19; tbit[1] = 1'b0;
    twid[2] = 28; tbit[2] = 1'b0;
    twid[3] = 29; tbit[3] = 1'b1;
    twid[4] = 39; tbit[4] = 1'b1;
    twid[5] = 62; tbit[5] = 1'b1;

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("reset pix outputs", {pix_valid, pix_green, pix_red, pix_blue, pix_index}, 32'h0);
    check("reset frame/err outputs", 32'({frame_done, frame_pixels, err_short, err_long,
                                          err_partial, err_overflow}), 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Initial sync low must not report a frame
    latch();
    check("sync no frame", 32'(fq.size()), 32'd0);

    // Single pixel G=10 R=FF B=00
    flush();
    send_bits({8'h10, 8'hFF, 8'h00}, 24);
    latch();
    check("t1 pix count", 32'(pq.size()), 32'd1);
    chk_pix("t1 pix", 0, 8'h10, 8'hFF, 8'h00, 7'd0);
    chk_frame("t1", 1, 7'd1);

    // Five pixels with inter-pixel stalls
    flush();
    for (int i = 0; i < 5; i++) begin
      send_bits({ptab[i].g, ptab[i].r, ptab[i].b}, 24);
      tick(300);
    end
    latch();
    check("t2 pix count", 32'(pq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk_pix($sformatf("t2 pix%0d", i), i, ptab[i].g, ptab[i].r, ptab[i].b, ptab[i].idx);
    chk_frame("t2", 1, 7'd5);
    check("t2 errors", 32'({err_short, err_long, err_partial, err_overflow}), 32'h0);

    // Threshold sweep: last bit of each pixel has the width under test
    flush();
    for (int i = 0; i < 6; i++) begin
      send_bits({8'hA5, 8'h3C, 8'hAA}, 23);
      pulse(twid[i], (62 - twid[i] < 10) ? 10 : 62 - twid[i]);
    end
    latch();
    for (int i = 0; i < 6; i++)
      chk_pix($sformatf("t3 width %0d", twid[i]), i, 8'hA5, 8'h3C, {7'b1010101, tbit[i]}, 7'(i));
    chk_frame("t3", 1, 7'd6);
    check("t3 errors", 32'({err_short, err_long, err_partial, err_overflow}), 32'h0);

    // 3-clk glitch mid-pixel: flagged and discarded without consuming a bit
    flush();
    send_bits(24'h5AC3F0, 12);
    pulse(3, 40);
    send_bits(24'h5AC3F0 << 12, 12);
    latch();
    chk_pix("t4 pix", 0, 8'h5A, 8'hC3, 8'hF0, 7'd0);
    check("t4 err_short set", 32'(err_short), 32'd1);
    chk_frame("t4", 1, 7'd1);
    clear_errs();
    check("t4 err_short cleared", 32'(err_short), 32'd0);

    // Partial word at latch
    flush();
    send_bits(24'h123456, 12);
    latch();
    check("t5 no pix", 32'(pq.size()), 32'd0);
    check("t5 no frame", 32'(fq.size()), 32'd0);
    check("t5 err_partial set", 32'(err_partial), 32'd1);
    send_bits({8'h81, 8'h42, 8'h24}, 24);
    latch();
    chk_pix("t5 pix", 0, 8'h81, 8'h42, 8'h24, 7'd0);
    chk_frame("t5", 1, 7'd1);
    clear_errs();
    check("t5 err_partial cleared", 32'(err_partial), 32'd0);

    // Over-long high: flag, ignore traffic until a full latch-length low
    flush();
    di = 1'b1;
    tick(100);
    di = 1'b0;
    tick(50);
    check("t6 err_long set", 32'(err_long), 32'd1);
    send_bits({8'hFF, 8'h00, 8'hFF}, 24);
    latch();
    check("t6 ignored pix", 32'(pq.size()), 32'd0);
    check("t6 ignored frame", 32'(fq.size()), 32'd0);
    send_bits({8'h0F, 8'hF0, 8'h55}, 24);
    latch();
    chk_pix("t6 pix", 0, 8'h0F, 8'hF0, 8'h55, 7'd0);
    chk_frame("t6", 1, 7'd1);
    clear_errs();
    check("t6 err_long cleared", 32'(err_long), 32'd0);

    // Reset mid-pixel, then resync and decode
    flush();
    send_bits(24'hDEADBE, 10);
    reset_n = 1'b0;
    tick(2);
    check("t7 reset pix outputs", {pix_valid, pix_green, pix_red, pix_blue, pix_index}, 32'h0);
    check("t7 reset frame/err", 32'({frame_done, frame_pixels, err_short, err_long,
                                     err_partial, err_overflow}), 32'h0);
    reset_n = 1'b1;
    latch();
    check("t7 sync no frame", 32'(fq.size()), 32'd0);
    send_bits({8'hC0, 8'hFF, 8'hEE}, 24);
    latch();
    chk_pix("t7 pix", 0, 8'hC0, 8'hFF, 8'hEE, 7'd0);
    chk_frame("t7", 1, 7'd1);
    check("t7 errors", 32'({err_short, err_long, err_partial, err_overflow}), 32'h0);

    // 61 zero pixels with short (5-clk) zero pulses: last one overflows
    flush();
    repeat (61) begin
      repeat (24) pulse(5, 5);
    end
    latch();
    check("t8 pix count", 32'(pq.size()), 32'd60);
    chk_pix("t8 last pix", 59, 8'h00, 8'h00, 8'h00, 7'd59);
    check("t8 err_overflow set", 32'(err_overflow), 32'd1);
    chk_frame("t8", 1, 7'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
